// File: rtl/mix_pkg.sv
// Shared encodings for the MIX shift unit.
// Holds field codes, FSM states and the normaliser flag bundle.
package mix_pkg;

    localparam logic [2:0] F_SLA  = 3'd0;
    localparam logic [2:0] F_SRA  = 3'd1;
    localparam logic [2:0] F_SLAX = 3'd2;
    localparam logic [2:0] F_SRAX = 3'd3;
    localparam logic [2:0] F_SLC  = 3'd4;
    localparam logic [2:0] F_SRC  = 3'd5;
    localparam logic [2:0] F_SLB  = 3'd6;
    localparam logic [2:0] F_SRB  = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic left;
        logic rot;
        logic a_only;
        logic err;
    } norm_flags_t;

endpackage

// File: rtl/mix_shift_norm.sv
// Combinational count normaliser: scales, wraps or saturates the
// requested count into a bit count and flags illegal requests.
module mix_shift_norm
    import mix_pkg::*;
#(
    parameter int BYTE_BITS = 6,
    parameter int NBYTES    = 5,
    parameter int M_BITS    = 12,
    localparam int W        = NBYTES * BYTE_BITS,
    localparam int S        = $clog2(2 * W)
) (
    input  logic [5:0]        field,
    input  logic [M_BITS-1:0] m,
    input  logic              m_neg,
    output logic [S-1:0]      cnt,
    output norm_flags_t       flags,
    output logic              zero
);

    logic [S-1:0] mlo;
    logic [S-1:0] mmod;

    assign mlo  = m[S-1:0];
    assign mmod = S'(m % M_BITS'(2 * NBYTES));

    always_comb begin
        cnt   = '0;
        flags = '0;
        zero  = 1'b0;
        if (field > 6'd7 || (m_neg && m != '0)) begin
            flags.err = 1'b1;
        end else begin
            // even codes shift left, odd codes shift right
            flags.left = ~field[0];
            unique case (field[2:0])
                F_SLA, F_SRA: begin
                    flags.a_only = 1'b1;
                    if (m >= M_BITS'(NBYTES))
                        zero = 1'b1;
                    else
                        cnt = S'(mlo * BYTE_BITS);
                end
                F_SLAX, F_SRAX: begin
                    if (m >= M_BITS'(2 * NBYTES))
                        zero = 1'b1;
                    else
                        cnt = S'(mlo * BYTE_BITS);
                end
                F_SLC, F_SRC: begin
                    flags.rot = 1'b1;
                    cnt       = S'(mmod * BYTE_BITS);
                end
                F_SLB, F_SRB: begin
                    if (m >= M_BITS'(2 * W))
                        zero = 1'b1;
                    else
                        cnt = mlo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mix_shifter.sv
// MIX shift unit: captures a request, normalises the count, then runs
// a log-depth barrel shift one stage per cycle over the {A,X} pair.
module mix_shifter
    import mix_pkg::*;
#(
    parameter int BYTE_BITS = 6,
    parameter int NBYTES    = 5,
    parameter int M_BITS    = 12,
    localparam int W        = NBYTES * BYTE_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        field,
    input  logic [M_BITS-1:0] m,
    input  logic              m_neg,
    input  logic [W-1:0]      ina,
    input  logic [W-1:0]      inx,
    input  logic              kill,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [W-1:0]      outa,
    output logic [W-1:0]      outx
);

    localparam int S  = $clog2(2 * W);
    localparam int KW = (S > 1) ? $clog2(S) : 1;

    logic [1:0]        state;
    logic [5:0]        fld_r;
    logic [M_BITS-1:0] m_r;
    logic              mneg_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      x_r;
    logic [2*W-1:0]    d;
    logic [2*W-1:0]    d_step;
    logic [S-1:0]      cnt_r;
    norm_flags_t       fl_r;
    logic [KW-1:0]     k;

    logic [S-1:0]      n_cnt;
    norm_flags_t       n_fl;
    logic              n_zero;
    int unsigned       amt;

    mix_shift_norm #(
        .BYTE_BITS (BYTE_BITS),
        .NBYTES    (NBYTES),
        .M_BITS    (M_BITS)
    ) u_norm (
        .field (fld_r),
        .m     (m_r),
        .m_neg (mneg_r),
        .cnt   (n_cnt),
        .flags (n_fl),
        .zero  (n_zero)
    );

    // stage k moves by 2^k bits when count bit k is set
    always_comb begin
        amt    = 32'd1 << k;
        d_step = d;
        if (cnt_r[k]) begin
            if (fl_r.rot)
                d_step = fl_r.left
                       ? ((d << amt) | (d >> (2 * W - amt)))
                       : ((d >> amt) | (d << (2 * W - amt)));
            else
                d_step = fl_r.left ? (d << amt) : (d >> amt);
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_DONE) & fl_r.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            fld_r  <= '0;
            m_r    <= '0;
            mneg_r <= 1'b0;
            a_r    <= '0;
            x_r    <= '0;
            d      <= '0;
            cnt_r  <= '0;
            fl_r   <= '0;
            k      <= '0;
            outa   <= '0;
            outx   <= '0;
        end else if (kill && state != ST_IDLE) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        fld_r  <= field;
                        m_r    <= m;
                        mneg_r <= m_neg;
                        a_r    <= ina;
                        x_r    <= inx;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    cnt_r <= n_cnt;
                    fl_r  <= n_fl;
                    k     <= '0;
                    // A-only modes shift A against a zero X half
                    if (n_zero)
                        d <= '0;
                    else if (n_fl.a_only)
                        d <= {a_r, {W{1'b0}}};
                    else
                        d <= {a_r, x_r};
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    d <= d_step;
                    k <= k + 1'b1;
                    if (k == KW'(S - 1)) begin
                        outa  <= d_step[2*W-1:W];
                        outx  <= fl_r.a_only ? x_r : d_step[W-1:0];
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_shifter.sv
// Randomised and directed bench for mix_shifter against a value-level
// model of the MIX shift instructions.
module tb_mix_shifter;

    localparam int W   = 30;
    localparam int S   = 6;
    // done shows S+2 cycles counting the accept cycle itself
    localparam int LAT = S + 1;
    localparam logic [63:0] MASK2 = 64'h0FFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          kill = 1'b0;
    logic          m_neg = 1'b0;
    logic [5:0]    field = '0;
    logic [11:0]   m = '0;
    logic [W-1:0]  ina = '0;
    logic [W-1:0]  inx = '0;
    logic          busy, done, err;
    logic [W-1:0]  outa, outx;

    int            checks = 0;
    int            errors = 0;
    int            ndone = 0;
    bit            mon_en = 1'b0;
    logic [W-1:0]  exp_a = '0, exp_x = '0;
    logic [W-1:0]  hold_a = '0, hold_x = '0;
    logic          exp_err = 1'b0;

    always #5 clk = ~clk;

    mix_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .field (field),
        .m     (m),
        .m_neg (m_neg),
        .ina   (ina),
        .inx   (inx),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .outa  (outa),
        .outx  (outx)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [W-1:0] pack(input int b4, input int b3,
                                          input int b2, input int b1,
                                          input int b0);
        return {6'(b4), 6'(b3), 6'(b2), 6'(b1), 6'(b0)};
    endfunction

    // returns {err, A, X}
    function automatic logic [2*W:0] model(input int f, input int mv,
                                           input bit mn,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] x);
        logic [63:0] ax;
        logic [63:0] v;
        logic [W-1:0] ra;
        int r;
        ax = {4'b0, a, x};
        if (f > 7 || (mn && mv != 0))
            return {1'b1, a, x};
        v = ax;
        case (f)
            0: begin
                ra = (mv >= 5) ? '0 : W'(a << (mv * 6));
                return {1'b0, ra, x};
            end
            1: begin
                ra = (mv >= 5) ? '0 : W'(a >> (mv * 6));
                return {1'b0, ra, x};
            end
            2: v = (mv >= 10) ? 64'd0 : ((ax << (mv * 6)) & MASK2);
            3: v = (mv >= 10) ? 64'd0 : (ax >> (mv * 6));
            4: begin
                r = (mv % 10) * 6;
                if (r != 0) v = ((ax << r) | (ax >> (60 - r))) & MASK2;
            end
            5: begin
                r = (mv % 10) * 6;
                if (r != 0) v = ((ax >> r) | (ax << (60 - r))) & MASK2;
            end
            6: v = (mv >= 60) ? 64'd0 : ((ax << mv) & MASK2);
            default: v = (mv >= 60) ? 64'd0 : (ax >> mv);
        endcase
        return {1'b0, v[59:30], v[29:0]};
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (done) begin
                ndone++;
                chk("res_a", outa, exp_a);
                chk("res_x", outx, exp_x);
                chk("res_err", err, exp_err);
                hold_a = exp_a;
                hold_x = exp_x;
            end else if (!busy) begin
                chk("hold_a", outa, hold_a);
                chk("hold_x", outx, hold_x);
                chk("idle_err", err, 1'b0);
            end
        end
    end

    task automatic run(input int f, input int mv, input bit mn,
                       input logic [W-1:0] a, input logic [W-1:0] x,
                       input bit glitch);
        int lat;
        @(posedge clk); #1;
        field = 6'(f); m = 12'(mv); m_neg = mn; ina = a; inx = x;
        {exp_err, exp_a, exp_x} = model(f, mv, mn, a, x);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            if (glitch && lat == 2) begin
                start = 1'b1; field = 6'd7; m = 12'd1;
                ina = ~a; inx = ~x;
            end
            if (glitch && lat == 4) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, LAT);
        @(posedge clk); #1;
        chk("busy_after", busy, 1'b0);
    endtask

    logic [W-1:0] A0, X0;
    int d0;

    initial begin
        A0 = pack(1, 2, 3, 4, 5);
        X0 = pack(6, 7, 8, 9, 10);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_a", outa, 0);
        chk("rst_x", outx, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        run(0, 2, 0, A0, X0, 0);
        chk("sla2_a", outa, pack(3, 4, 5, 0, 0));
        chk("sla2_x", outx, X0);
        run(3, 1, 0, A0, X0, 0);
        chk("srax1_a", outa, pack(0, 1, 2, 3, 4));
        chk("srax1_x", outx, pack(5, 6, 7, 8, 9));
        run(0, 5, 0, A0, X0, 0);
        chk("sla5_a", outa, 0);
        chk("sla5_x", outx, X0);
        run(4, 17, 0, A0, X0, 0);
        chk("slc17_a", outa, pack(8, 9, 10, 1, 2));
        chk("slc17_x", outx, pack(3, 4, 5, 6, 7));
        run(5, 3, 0, A0, X0, 0);
        chk("src3_a", outa, pack(8, 9, 10, 1, 2));
        chk("src3_x", outx, pack(3, 4, 5, 6, 7));
        run(7, 3, 0, 0, 30'd8, 0);
        chk("srb3_x", outx, 30'd1);
        run(6, 60, 0, A0, X0, 0);
        chk("slb60_a", outa, 0);
        chk("slb60_x", outx, 0);
        run(9, 1, 0, A0, X0, 0);
        chk("f9_a", outa, A0);
        chk("f9_x", outx, X0);
        run(2, 0, 1, A0, X0, 0);
        chk("negz_a", outa, A0);
        run(1, 2, 1, A0, X0, 0);
        chk("neg_a", outa, A0);

        run(0, 2, 0, A0, X0, 1);
        chk("glitch_a", outa, pack(3, 4, 5, 0, 0));

        // abort in SHIFT: no completion, old results stay
        @(posedge clk); #1;
        field = 6'd4; m = 12'd3; m_neg = 0; ina = X0; inx = A0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", busy, 1'b0);
        d0 = ndone;
        repeat (12) @(posedge clk);
        #1;
        chk("kill_nodone", ndone, d0);
        chk("kill_hold_a", outa, pack(3, 4, 5, 0, 0));

        // reset mid-operation
        @(posedge clk); #1;
        field = 6'd2; m = 12'd1; ina = A0; inx = X0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_a", outa, 0);
        chk("mrst_x", outx, 0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err", err, 1'b0);
        hold_a = '0;
        hold_x = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = ndone;
        repeat (12) @(posedge clk);
        #1;
        chk("mrst_nodone", ndone, d0);

        for (int i = 0; i < 150; i++) begin
            int f, mv;
            bit mn;
            f = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: mv = $urandom_range(0, 12);
                1: mv = $urandom_range(0, 70);
                2: mv = $urandom_range(0, 4095);
                default: mv = 0;
            endcase
            mn = ($urandom_range(0, 7) == 0);
            run(f, mv, mn, W'($urandom()), W'($urandom()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_shifter.md
MIX_SHIFTER -- requirements
Module: mix_shifter

Interface
REQ-001 The block SHALL have parameter BYTE_BITS, default 6, giving bits per MIX byte.
REQ-002 The block SHALL have parameter NBYTES, default 5, giving bytes per register magnitude; W = NBYTES*BYTE_BITS.
REQ-003 The block SHALL have parameter M_BITS, default 12, giving the shift-count width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request; accepted only when busy=0.
REQ-007 The block SHALL have port field, input, 6 bits: mode; 0 SLA, 1 SRA, 2 SLAX, 3 SRAX, 4 SLC, 5 SRC, 6 SLB, 7 SRB.
REQ-008 The block SHALL have port m, input, M_BITS bits: unsigned shift count magnitude.
REQ-009 The block SHALL have port m_neg, input, 1 bit: shift count sign.
REQ-010 The block SHALL have ports ina and inx, input, W bits each: rA and rX magnitudes (signs handled outside this block).
REQ-011 The block SHALL have port kill, input, 1 bit: synchronous abort.
REQ-012 The block SHALL have ports busy, done and err, output, 1 bit each: operation in flight, one-cycle completion pulse, and illegal-request flag valid with done.
REQ-013 The block SHALL have ports outa and outx, output, W bits each: results, held stable from done until the next accepted start.

Function
REQ-014 The block SHALL capture field, m, m_neg, ina and inx on the edge where start=1 and busy=0; start while busy=1 SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, NORM, SHIFT and DONE; IDLE->NORM on accept, NORM->SHIFT, SHIFT for S=clog2(2W) cycles, SHIFT->DONE, DONE->IDLE.
REQ-016 busy SHALL be 1 in NORM, SHIFT and DONE; done SHALL be 1 only in DONE; done SHALL occur exactly S+2 edges after the accept edge, independent of count and mode.
REQ-017 In NORM, the effective bit count SHALL be m*BYTE_BITS for byte modes and m for SLB/SRB.
REQ-018 For SLC/SRC, the count SHALL be m mod 2*NBYTES, rotating the 2W-bit ring {A,X}.
REQ-019 For SLA/SRA, when m>=NBYTES, outa SHALL be 0; X SHALL never change.
REQ-020 For SLAX/SRAX, when m>=2*NBYTES, the result SHALL be all-zero; for SLB/SRB the same SHALL apply when m>=2W.
REQ-021 Non-circular modes SHALL zero-fill; SLAX/SLB SHALL shift X's high bits into A's low bits, and SRAX/SRB SHALL shift A's low bits into X's high bits.
REQ-022 SHIFT cycle k (k=0..S-1) SHALL apply a shift/rotate of 2^k bits when bit k of the effective count is set, and otherwise pass the data through.
REQ-023 When m_neg=1 with m!=0, or field>7, outa/outx SHALL equal ina/inx and err SHALL be 1 during done; m_neg=1 with m=0 SHALL be a legal zero shift.
REQ-024 m=0 in any legal mode SHALL return the inputs unchanged with err=0.
REQ-025 kill=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse, leaving outa/outx at their previous values; kill in IDLE SHALL have no effect; kill SHALL have priority over start.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, outa=0 and outx=0, including mid-operation; no done SHALL follow release.
REQ-027 The first start SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-028 Field encodings 0-7 and the FSM state encodings SHALL reside in shared package mix_pkg.
REQ-029 Count normalisation (scaling, modulo, saturate-to-zero, err detection) SHALL be a combinational sub-module mix_shift_norm; the stage shifter and FSM SHALL remain in mix_shifter.

Verification (defaults; bytes in decimal; A=01 02 03 04 05, X=06 07 08 09 10)
REQ-030 SLA m=2 -> A=03 04 05 00 00, X unchanged, done exactly 8 edges after accept, err=0.
REQ-031 SRAX m=1 -> A=00 01 02 03 04, X=05 06 07 08 09; SLA m=5 -> A=0, X unchanged.
REQ-032 SLC m=17 (17 mod 10 = 7) -> A=08 09 10 01 02, X=03 04 05 06 07; SRC m=3 -> A=08 09 10 01 02, X=03 04 05 06 07.
REQ-033 SRB m=3 with A=0, X=8 -> X=1; SLB m=60 -> A=X=0; field=9 -> outputs equal inputs, err=1.
REQ-034 Start during busy ignored; kill in SHIFT -> no done, prior outputs held; rst_n low in SHIFT -> all outputs 0 at once, no done after release.
